// File: rtl/fxp_pkg.sv
// Shared width helpers, saturation limits and binary-point alignment for the
// fixed-point MAC datapath.
package fxp_pkg;

  typedef struct packed {
    logic valid;
    logic last;
  } stage_ctl_t;

  typedef struct packed {
    longint hi;
    longint lo;
  } sat_lim_t;

  function automatic int prod_width(int i1, int f1, int i2, int f2);
    return i1 + f1 + i2 + f2;
  endfunction

  function automatic int acc_width(int i1, int f1, int i2, int f2, int guard);
    return prod_width(i1, f1, i2, f2) + guard;
  endfunction

  // Limits are expressed in units of the result LSB.
  function automatic sat_lim_t sat_limits(int i3, int f3, bit osign);
    sat_lim_t lim;
    if (osign) begin
      lim.hi = (64'sd1 <<< (i3 + f3 - 1)) - 64'sd1;
      lim.lo = -(64'sd1 <<< (i3 + f3 - 1));
    end else begin
      lim.hi = (64'sd1 <<< (i3 + f3)) - 64'sd1;
      lim.lo = 64'sd0;
    end
    return lim;
  endfunction

  function automatic longint align_round(longint v, int frac_in, int frac_out, bit round_en);
    longint r;
    r = v;
    if (frac_out >= frac_in) begin
      r = v <<< (frac_out - frac_in);
    end else begin
      if (round_en) r = r + (64'sd1 <<< (frac_in - frac_out - 1));
      r = r >>> (frac_in - frac_out);
    end
    return r;
  endfunction

endpackage

// File: rtl/fxp_mac_stream_if.sv
// Stream bundle for the MAC: two joined operand streams in, one result stream out.
interface fxp_mac_stream_if #(
  parameter int AW = 16,
  parameter int BW = 16,
  parameter int OW = 16
);

  logic [AW-1:0] input_tdata_a;
  logic          input_tvalid_a;
  logic          input_tlast_a;
  logic          input_tready_a;
  logic [BW-1:0] input_tdata_b;
  logic          input_tvalid_b;
  logic          input_tready_b;
  logic [OW-1:0] output_tdata;
  logic          output_tvalid;
  logic          output_tready;
  logic          overflow;

  modport slave (
    input  input_tdata_a, input_tvalid_a, input_tlast_a,
    output input_tready_a,
    input  input_tdata_b, input_tvalid_b,
    output input_tready_b,
    output output_tdata, output_tvalid, overflow,
    input  output_tready
  );

  modport master (
    output input_tdata_a, input_tvalid_a, input_tlast_a,
    input  input_tready_a,
    output input_tdata_b, input_tvalid_b,
    input  input_tready_b,
    input  output_tdata, output_tvalid, overflow,
    output output_tready
  );

endinterface

// File: rtl/fxp_sat_round.sv
// Combinational align/round/saturate from accumulator format to i3.f3.
// Define FXP_MAC_ROUND_EN for round-half-up; otherwise truncation toward -inf.
module fxp_sat_round
  import fxp_pkg::*;
#(
  parameter int IW    = 36,
  parameter int IFRAC = 28,
  parameter bit ISIGN = 1'b1,
  parameter int I3    = 2,
  parameter int F3    = 14,
  parameter bit OSIGN = 1'b1
) (
  input  logic [IW-1:0]    acc,
  output logic [I3+F3-1:0] data,
  output logic             sat
);

  localparam int       OW  = I3 + F3;
  localparam sat_lim_t LIM = sat_limits(I3, F3, OSIGN);
`ifdef FXP_MAC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  longint v;
  longint r;
  longint hi;
  longint lo;

  always_comb begin
    hi = LIM.hi;
    lo = LIM.lo;
    if (ISIGN) v = longint'(signed'(acc));
    else       v = longint'(acc);
    // Rounding happens before the compare so a rounding carry saturates.
    r    = align_round(v, IFRAC, F3, RND);
    sat  = 1'b0;
    data = r[OW-1:0];
    if (r > hi) begin
      data = hi[OW-1:0];
      sat  = 1'b1;
    end else if (r < lo) begin
      data = lo[OW-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fxp_mac_stream.sv
// Streaming fixed-point MAC: join A/B, multiply, accumulate to tlast, emit a
// saturated i3.f3 result. Rounding selected by FXP_MAC_ROUND_EN (in fxp_sat_round).
module fxp_mac_stream
  import fxp_pkg::*;
#(
  parameter int i1    = 2,
  parameter int f1    = 14,
  parameter int i2    = 2,
  parameter int f2    = 14,
  parameter int i3    = 2,
  parameter int f3    = 14,
  parameter bit sign1 = 1'b1,
  parameter bit sign2 = 1'b1,
  parameter bit osign = sign1 || sign2,
  parameter int GUARD = 4
) (
  input logic        clk,
  input logic        reset,
  fxp_mac_stream_if.slave bus
);

  localparam int AW    = i1 + f1;
  localparam int BW    = i2 + f2;
  localparam int PW    = prod_width(i1, f1, i2, f2);
  localparam int ACW   = acc_width(i1, f1, i2, f2, GUARD);
  localparam int OW    = i3 + f3;
  localparam int SW    = ACW + 2;
  localparam bit PSIGN = sign1 || sign2;

  logic adv;
  logic accept;

  logic signed [PW:0] a_x;
  logic signed [PW:0] b_x;
  logic signed [PW:0] p_now;

  stage_ctl_t         s1;
  logic signed [PW:0] s1_prod;

  logic [ACW-1:0] acc_q;
  logic           wrap_q;
  logic           s2_valid;
  logic [ACW-1:0] s2_sum;
  logic           s2_wrap;

  logic [SW-1:0] acc_se;
  logic [SW-1:0] p_se;
  logic [SW-1:0] sum;
  logic [2:0]    top3;
  logic          wrap_now;

  logic [OW-1:0] sr_data;
  logic          sr_sat;

  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ovf;

  assign adv    = !out_valid || bus.output_tready;
  assign accept = adv && !reset && bus.input_tvalid_a && bus.input_tvalid_b;

  assign bus.input_tready_a = accept;
  assign bus.input_tready_b = accept;
  assign bus.output_tvalid  = out_valid;
  assign bus.output_tdata   = out_data;
  assign bus.overflow       = out_ovf;

  // One extra bit lets an unsigned operand sit in a signed multiply.
  always_comb begin
    a_x = sign1 ? {{(PW+1-AW){bus.input_tdata_a[AW-1]}}, bus.input_tdata_a}
                : {{(PW+1-AW){1'b0}}, bus.input_tdata_a};
    b_x = sign2 ? {{(PW+1-BW){bus.input_tdata_b[BW-1]}}, bus.input_tdata_b}
                : {{(PW+1-BW){1'b0}}, bus.input_tdata_b};
    p_now = a_x * b_x;
  end

  // Two headroom bits above ACC make wrap detection a simple top-bits check.
  always_comb begin
    acc_se   = PSIGN ? {{2{acc_q[ACW-1]}}, acc_q} : {2'b00, acc_q};
    p_se     = {{(SW-PW-1){s1_prod[PW]}}, s1_prod};
    sum      = acc_se + p_se;
    top3     = sum[SW-1:ACW-1];
    wrap_now = PSIGN ? (top3 != 3'b000 && top3 != 3'b111) : (top3[2:1] != 2'b00);
  end

  fxp_sat_round #(
    .IW    (ACW),
    .IFRAC (f1 + f2),
    .ISIGN (PSIGN),
    .I3    (i3),
    .F3    (f3),
    .OSIGN (osign)
  ) u_sat_round (
    .acc  (s2_sum),
    .data (sr_data),
    .sat  (sr_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s1_prod   <= '0;
      acc_q     <= '0;
      wrap_q    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_sum    <= '0;
      s2_wrap   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      s1.valid <= accept;
      s1.last  <= bus.input_tlast_a;
      if (accept) s1_prod <= p_now;

      s2_valid <= s1.valid && s1.last;
      if (s1.valid) begin
        if (s1.last) begin
          s2_sum  <= sum[ACW-1:0];
          s2_wrap <= wrap_q | wrap_now;
          acc_q   <= '0;
          wrap_q  <= 1'b0;
        end else begin
          acc_q  <= sum[ACW-1:0];
          wrap_q <= wrap_q | wrap_now;
        end
      end

      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= sr_data;
        out_ovf  <= sr_sat | s2_wrap;
      end
    end
  end

endmodule

// File: tb/tb_fxp_mac_stream.sv
// Scoreboard bench for fxp_mac_stream at default Q2.14 operands and result.
module tb_fxp_mac_stream;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fxp_mac_stream_if #(.AW(16), .BW(16), .OW(16)) bus();

  fxp_mac_stream dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef FXP_MAC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors       = 0;
  int   miscompares   = 0;
  int   cyc           = 0;
  int   n_pushed      = 0;
  int   n_popped      = 0;
  int   last_beat_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops on every completed output handshake, checks holding while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.output_tvalid) begin
        if (bus.output_tready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_result: got data 0x%0h with no result outstanding, expected none", bus.output_tdata);
          end else begin
            mon_e = sb.pop_front();
            n_popped++;
            check("result_data", bus.output_tdata, mon_e.data);
            check("result_ovf", bus.overflow, mon_e.ovf);
          end
        end else if (sb.size() != 0) begin
          check("held_data", bus.output_tdata, sb[0].data);
          check("held_ovf", bus.overflow, sb[0].ovf);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                      input logic [15:0] ed, input logic eo);
    bit done;
    done = 1'b0;
    bus.input_tdata_a  = a;
    bus.input_tdata_b  = b;
    bus.input_tlast_a  = last;
    bus.input_tvalid_a = 1'b1;
    bus.input_tvalid_b = 1'b1;
    if (last) begin
      sb.push_back('{data: ed, ovf: eo});
      n_pushed++;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.input_tready_a && bus.input_tready_b) begin
        last_beat_cyc = cyc;
        @(posedge clk);
        done = 1'b1;
      end
    end
    #1;
    bus.input_tvalid_a = 1'b0;
    bus.input_tvalid_b = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: beat A=0x%0h B=0x%0h not accepted, expected acceptance", a, b);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    reset              = 1'b1;
    bus.output_tready  = 1'b1;
    bus.input_tdata_a  = 16'h0000;
    bus.input_tdata_b  = 16'h0000;
    bus.input_tlast_a  = 1'b0;
    bus.input_tvalid_a = 1'b1;
    bus.input_tvalid_b = 1'b1;

    // Reset state, with both valids high to prove tready is gated.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready_a", bus.input_tready_a, 1'b0);
    check("rst_tready_b", bus.input_tready_b, 1'b0);
    check("rst_tvalid", bus.output_tvalid, 1'b0);
    check("rst_tdata", bus.output_tdata, 16'h0000);
    check("rst_ovf", bus.overflow, 1'b0);
    bus.input_tvalid_a = 1'b0;
    bus.input_tvalid_b = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // 0.5*0.5 + 0.5*0.5 = 0.5, with latency measured from the last beat.
    send(16'h2000, 16'h2000, 1'b0, 16'h0000, 1'b0);
    send(16'h2000, 16'h2000, 1'b1, 16'h2000, 1'b0);
    k = 0;
    while (!bus.output_tvalid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", cyc - last_beat_cyc, 3);
    drain();

    // Saturation, back-to-back single-beat and multi-beat vectors.
    send(16'h6000, 16'h6000, 1'b1, 16'h7FFF, 1'b1);
    send(16'h8000, 16'h6000, 1'b1, 16'h8000, 1'b1);
    send(16'h4000, 16'h4000, 1'b0, 16'h0000, 1'b0);
    send(16'h4000, 16'h2000, 1'b0, 16'h0000, 1'b0);
    send(16'hC000, 16'h2000, 1'b1, 16'h4000, 1'b0);
    send(16'h6000, 16'h4000, 1'b0, 16'h0000, 1'b0);
    send(16'h6000, 16'h4000, 1'b1, 16'h7FFF, 1'b1);

    // Half-LSB cases: rounding versus truncation toward -inf.
    send(16'h0001, 16'h2000, 1'b1, RND ? 16'h0001 : 16'h0000, 1'b0);
    send(16'hFFFF, 16'h2000, 1'b1, RND ? 16'h0000 : 16'hFFFF, 1'b0);
    drain();

    // Backpressure: three results queued behind a stalled output.
    bus.output_tready = 1'b0;
    send(16'h2000, 16'h4000, 1'b1, 16'h2000, 1'b0);
    send(16'h6000, 16'hA000, 1'b1, 16'h8000, 1'b1);
    send(16'h1000, 16'h1000, 1'b1, 16'h0400, 1'b0);
    bus.input_tdata_a  = 16'h7FFF;
    bus.input_tdata_b  = 16'h0000;
    bus.input_tlast_a  = 1'b1;
    bus.input_tvalid_a = 1'b1;
    bus.input_tvalid_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_tready_a", bus.input_tready_a, 1'b0);
      check("stall_tready_b", bus.input_tready_b, 1'b0);
    end
    @(posedge clk);
    #1 bus.output_tready = 1'b1;
    send(16'h7FFF, 16'h0000, 1'b1, 16'h0000, 1'b0);
    drain();

    // Join: A alone must not be consumed.
    bus.input_tdata_a  = 16'h4000;
    bus.input_tdata_b  = 16'hC000;
    bus.input_tlast_a  = 1'b1;
    bus.input_tvalid_a = 1'b1;
    bus.input_tvalid_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("join_tready_a", bus.input_tready_a, 1'b0);
      check("join_tready_b", bus.input_tready_b, 1'b0);
    end
    @(posedge clk);
    #1;
    send(16'h4000, 16'hC000, 1'b1, 16'hC000, 1'b0);
    drain();

    // Mid-vector reset discards the partial sum.
    send(16'h4000, 16'h4000, 1'b0, 16'h0000, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 16'h0000, 1'b0);
    reset              = 1'b1;
    bus.input_tvalid_a = 1'b1;
    bus.input_tvalid_b = 1'b1;
    @(negedge clk);
    check("midrst_tready_a", bus.input_tready_a, 1'b0);
    @(posedge clk);
    #1;
    reset              = 1'b0;
    bus.input_tvalid_a = 1'b0;
    bus.input_tvalid_b = 1'b0;
    send(16'h4000, 16'h4000, 1'b1, 16'h4000, 1'b0);
    send(16'h2000, 16'h2000, 1'b1, 16'h1000, 1'b0);
    drain();

    check("result_count", n_popped, n_pushed);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
